// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory, the fetch stage and the boot loader.
package prog_mem_pkg;

  // Default geometry of the program store.
  localparam int DEF_DATA_W = 15;
  localparam int DEF_ADDR_W = 8;

  // Word written everywhere by the hardware clear sequence.
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = '0;

  // CLEAR fills the array after reset; RUN is terminal until the next reset.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Single-clock DEPTH x DATA_W storage with one write port and one registered,
// write-first read port.
module prog_mem_array #(
  parameter int                DATA_W   = 15,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_bypass;

  // A same-edge write to the fetched address forwards the new word.
  assign w_bypass = i_we && (i_waddr == i_raddr);

  // Storage write; the array itself is never reset, the clear engine overwrites it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= NOP_WORD;
    end else if (i_re) begin
      r_rdata <= w_bypass ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_memory.sv
// Writable program memory: clear-after-reset engine, registered fetch port
// with valid pulse, and a run-time programming port with ack/err pulses.
module prog_memory
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  output logic              prog_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clear_ptr;
  logic              r_fetch_valid;
  logic              r_prog_ack;
  logic              r_prog_err;

  logic              w_run;
  logic              w_fetch_acc;
  logic              w_prog_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_run       = (r_state == RUN);
  assign w_fetch_acc = fetch_req && w_run;
  assign w_prog_acc  = prog_we && w_run;

  // Write-port mux: the clear engine owns the port until RUN, then prog_* does.
  assign w_we    = w_run ? prog_we   : 1'b1;
  assign w_waddr = w_run ? prog_addr : r_clear_ptr;
  assign w_wdata = w_run ? prog_data : NOP_WORD;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave CLEAR on the edge that writes the last word.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && (r_clear_ptr == {ADDR_W{1'b1}})) begin
      w_state_nxt = RUN;
    end
  end

  // Clear pointer walks every address once; it stops mattering in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clear_ptr <= '0;
    end else if (!w_run) begin
      r_clear_ptr <= r_clear_ptr + 1'b1;
    end
  end

  // One-cycle handshake pulses for fetch and program writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_prog_ack    <= 1'b0;
      r_prog_err    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_acc;
      r_prog_ack    <= w_prog_acc;
      r_prog_err    <= prog_we && !w_run;
    end
  end

  prog_mem_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NOP_WORD(NOP_WORD)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_re   (w_fetch_acc),
    .i_raddr(fetch_addr),
    .o_rdata(fetch_data)
  );

  assign fetch_valid = r_fetch_valid;
  assign ready       = w_run;
  assign prog_ack    = r_prog_ack;
  assign prog_err    = r_prog_err;

endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory: default instance plus a 24-bit x 16 instance.
module tb_prog_memory;

  localparam int DW    = 15;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int BDW   = 24;
  localparam int BAW   = 4;
  localparam int BDEP  = 16;
  localparam logic [BDW-1:0] BNOP = 24'hABCDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          ready;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_ack;
  logic          prog_err;

  logic           b_fetch_req;
  logic [BAW-1:0] b_fetch_addr;
  logic [BDW-1:0] b_fetch_data;
  logic           b_fetch_valid;
  logic           b_ready;
  logic           b_prog_we;
  logic [BAW-1:0] b_prog_addr;
  logic [BDW-1:0] b_prog_data;
  logic           b_prog_ack;
  logic           b_prog_err;

  prog_memory dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .ready      (ready),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_ack   (prog_ack),
    .prog_err   (prog_err)
  );

  prog_memory #(
    .DATA_W  (BDW),
    .ADDR_W  (BAW),
    .NOP_WORD(BNOP)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (b_fetch_req),
    .fetch_addr (b_fetch_addr),
    .fetch_data (b_fetch_data),
    .fetch_valid(b_fetch_valid),
    .ready      (b_ready),
    .prog_we    (b_prog_we),
    .prog_addr  (b_prog_addr),
    .prog_data  (b_prog_data),
    .prog_ack   (b_prog_ack),
    .prog_err   (b_prog_err)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_data;
  logic          model_ready;
  int            clr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fetch_req    = 1'b0;
    fetch_addr   = '0;
    prog_we      = 1'b0;
    prog_addr    = '0;
    prog_data    = '0;
    b_fetch_req  = 1'b0;
    b_fetch_addr = '0;
    b_prog_we    = 1'b0;
    b_prog_addr  = '0;
    b_prog_data  = '0;
  endtask

  // Reference view after a reset: the clear sequence leaves every word at NOP.
  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    model_ready = 1'b0;
    clr_cnt     = 0;
    last_data   = '0;
    exp_q.delete();
  endtask

  // One clock: record expectations from the driven inputs, clock, compare.
  task automatic step();
    logic          exp_ack;
    logic          exp_err;
    logic          exp_bvld;
    logic [DW-1:0] exp_d;
    exp_ack  = prog_we && model_ready;
    exp_err  = prog_we && !model_ready && rst_n;
    exp_bvld = b_fetch_req && (model_ready || clr_cnt >= BDEP) && rst_n;
    if (fetch_req && model_ready) begin
      if (prog_we && (prog_addr == fetch_addr)) exp_q.push_back(prog_data);
      else                                      exp_q.push_back(mem_m[fetch_addr]);
    end
    if (prog_we && model_ready) mem_m[prog_addr] = prog_data;
    @(posedge clk);
    #1;
    if (!model_ready && rst_n) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) model_ready = 1'b1;
    end
    chk("fetch_valid", 32'(fetch_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      exp_d     = exp_q.pop_front();
      last_data = exp_d;
    end
    chk("fetch_data", 32'(fetch_data), 32'(last_data));
    chk("prog_ack", 32'(prog_ack), 32'(exp_ack));
    chk("prog_err", 32'(prog_err), 32'(exp_err));
    chk("ready", 32'(ready), 32'(model_ready));
    chk("b_ready", 32'(b_ready), 32'(model_ready || clr_cnt >= BDEP));
    chk("b_fetch_valid", 32'(b_fetch_valid), 32'(exp_bvld));
    idle();
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;

    // Reset values.
    chk("rst_fetch_data", 32'(fetch_data), 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_prog_ack", 32'(prog_ack), 32'h0);
    chk("rst_prog_err", 32'(prog_err), 32'h0);
    chk("rst_b_fetch_data", 32'(b_fetch_data), 32'(BNOP));
    chk("rst_b_ready", 32'(b_ready), 32'h0);

    // Clear sequence: a dropped write at edge 10, an ignored fetch at edge 20.
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      if (e == 10) begin
        prog_we   = 1'b1;
        prog_addr = 8'h05;
        prog_data = 15'h1234;
      end
      if (e == 20) begin
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
      end
      step();
    end

    // Cleared words, back-to-back, and the dropped-write address.
    do_fetch(8'h00);
    do_fetch(8'h7F);
    do_fetch(8'hFF);
    do_fetch(8'h05);

    // Program two words and fetch them back-to-back.
    do_write(8'h00, 15'h0C0F);
    do_write(8'h01, 15'h4F00);
    do_fetch(8'h00);
    do_fetch(8'h01);
    step();

    // Same-edge write and fetch, same address: write-first.
    prog_we   = 1'b1;
    prog_addr = 8'h10;
    prog_data = 15'h7FFF;
    do_fetch(8'h10);

    // Same-edge write and fetch, different addresses: old content of 0x11.
    do_write(8'h11, 15'h2222);
    prog_we   = 1'b1;
    prog_addr = 8'h10;
    prog_data = 15'h0AAA;
    do_fetch(8'h11);
    do_fetch(8'h10);

    // Parameter-swept instance: top word reads its NOP.
    b_fetch_req  = 1'b1;
    b_fetch_addr = 4'hF;
    step();
    chk("b_fetch_data", 32'(b_fetch_data), 32'(BNOP));

    // Load 0x20, fetch it with a write in parallel, then reset mid-stream.
    do_write(8'h20, 15'h5555);
    prog_we   = 1'b1;
    prog_addr = 8'h22;
    prog_data = 15'h0001;
    do_fetch(8'h20);
    fetch_req  = 1'b1;
    fetch_addr = 8'h20;
    prog_we    = 1'b1;
    prog_addr  = 8'h21;
    prog_data  = 15'h3333;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fetch_data", 32'(fetch_data), 32'h0);
    chk("mid_rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_prog_ack", 32'(prog_ack), 32'h0);
    chk("mid_rst_prog_err", 32'(prog_err), 32'h0);
    idle();
    model_reset();
    step();
    step();

    // Second clear sequence after a mid-stream reset.
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) step();

    // Program loaded before the reset is gone.
    do_fetch(8'h20);
    do_fetch(8'h22);
    step();

    if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_memory.md
Name: prog_memory

Overview:
- Parametrised, writable program memory. Successor to the fixed 15-bit x 256 combinational program ROM.
- Provides a registered fetch port with valid handshake, a programming port for loading code at run time, and a hardware clear sequence that fills every word with NOP after reset.
- Sits between the PC/fetch stage and a boot loader or debug host.

Parameters:
- DATA_W, 15, instruction word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- NOP_WORD, 0 (DATA_W bits), value written to every word during the clear sequence.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; accepted on an edge where ready=1.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_data  out  DATA_W  registered instruction word.
- fetch_valid  out  1  one-cycle pulse: fetch_data holds the result of the fetch accepted on the previous edge.
- ready  out  1  high in state RUN only.
- prog_we  in  1  program-write strobe.
- prog_addr  in  ADDR_W  program-write address.
- prog_data  in  DATA_W  program-write data.
- prog_ack  out  1  one-cycle pulse after an accepted write.
- prog_err  out  1  one-cycle pulse after a write was dropped (ready=0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State CLEAR, clear_ptr=0.
  - Outputs: fetch_data=NOP_WORD, fetch_valid=0, ready=0, prog_ack=0, prog_err=0.
  - Memory array contents are not reset directly; the clear sequence overwrites them.
- State CLEAR:
  - Each edge writes NOP_WORD to mem[clear_ptr], then increments clear_ptr.
  - On the edge that writes DEPTH-1, go to RUN.
  - ready therefore rises exactly DEPTH edges after rst_n deasserts (256 with defaults).
- State RUN: terminal; left only by reset.
- Fetch:
  - Accepted when fetch_req=1 and ready=1.
  - On that edge: fetch_data <= mem[fetch_addr] and fetch_valid <= 1.
  - Latency is 1 cycle; back-to-back fetches are allowed every cycle.
  - With no accepted fetch, fetch_valid <= 0 and fetch_data holds its last value.
  - fetch_req while ready=0 is ignored: no valid, no error.
- Program write:
  - In RUN, prog_we=1 writes mem[prog_addr] <= prog_data on the edge; prog_ack pulses the next cycle.
  - In CLEAR, the write is dropped and prog_err pulses the next cycle. The clear sequence is not disturbed.
- Simultaneous fetch and write, same address: write-first. fetch_data returns prog_data.
- Simultaneous fetch and write, different addresses: both complete independently.
- Address wrap: addresses are ADDR_W bits wide, so there are no out-of-range values. clear_ptr wraps to 0 after DEPTH-1, but is unused once in RUN.
- Reset mid-operation (during CLEAR or RUN):
  - Immediately returns to the reset values above.
  - The clear restarts from address 0; any partially loaded program is lost.
  - A fetch or write in flight is discarded: no valid, ack or err pulse.
- All widths follow the parameters; nothing is hard-coded to 15 or 8.

Decomposition:
- Shared package prog_mem_pkg:
  - state enum {CLEAR, RUN};
  - default NOP_WORD constant;
  - default DATA_W and ADDR_W constants, shared with the fetch stage and the loader.
- One sub-module, prog_mem_array:
  - single-clock memory, DEPTH x DATA_W;
  - one write port, muxed between the clear engine and prog_*;
  - one registered read port with write-first bypass.
- prog_memory holds the FSM, clear_ptr, the handshake/pulse registers and the write mux.

Test Plan:
- Reset release, defaults -> ready=0 for edges 1..255, ready=1 after edge 256; fetch of 0x00, 0x7F and 0xFF returns 0x0000 with fetch_valid one cycle later.
- prog_we at cycle 10 (CLEAR), addr 0x05, data 0x1234 -> prog_err pulses once, no prog_ack; after ready, fetch 0x05 returns 0x0000.
- In RUN: write 0x00=0x0C0F, 0x01=0x4F00, then fetch 0x00, 0x01 back-to-back -> prog_ack per write; fetch_valid high two consecutive cycles with 0x0C0F then 0x4F00.
- Same-edge write 0x10=0x7FFF and fetch 0x10 -> next cycle fetch_data=0x7FFF, fetch_valid=1, prog_ack=1. Repeat with fetch 0x11 -> returns the old content of 0x11.
- rst_n pulsed low mid-stream after 0x20=0x5555 -> outputs reset immediately; ready low again for 256 edges; fetch 0x20 then returns 0x0000.
- Parameter sweep DATA_W=24, ADDR_W=4, NOP_WORD=0xABCDEF -> ready after 16 edges; fetch 0xF returns 0xABCDEF.
